// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the I-cache refill controller
// and the D-cache refill/writeback controller. One requester owns the port for
// a whole burst of BEATS acknowledged word transfers. Contention is resolved
// round-robin. A one-cycle holdoff after every burst keeps a requester's
// stale request from being granted again.
module mem_arbiter #(
    parameter int BEATS = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic [XLEN-1:0] i_data,
    output logic            i_ack,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic [XLEN-1:0] d_data,
    output logic            d_ack,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_data,
    input  logic            mem_ack,
    output logic [1:0]      grant,
    output logic            busy
);

    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10,
        RELEASE = 2'b11
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] beat_cnt_r;
    logic [CNT_W-1:0] beat_cnt_next_s;
    logic             last_grant_r;       // 0 = I side, 1 = D side
    logic             last_grant_next_s;

    // State register, beat counter and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            beat_cnt_r   <= {CNT_W{1'b0}};
            last_grant_r <= 1'b1;          // I side wins the first tie
        end else begin
            state_r      <= next_state_s;
            beat_cnt_r   <= beat_cnt_next_s;
            last_grant_r <= last_grant_next_s;
        end
    end

    // Next-state: grant selection in IDLE, burst counting and abort while granted
    always_comb begin
        next_state_s      = state_r;
        beat_cnt_next_s   = beat_cnt_r;
        last_grant_next_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (i_req && (!d_req || last_grant_r)) begin
                    next_state_s      = GRANT_I;
                    beat_cnt_next_s   = {CNT_W{1'b0}};
                    last_grant_next_s = 1'b0;
                end else if (d_req) begin
                    next_state_s      = GRANT_D;
                    beat_cnt_next_s   = {CNT_W{1'b0}};
                    last_grant_next_s = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GRANT_I: begin
                if (!i_req) begin
                    next_state_s = RELEASE;
                end else if (mem_ack) begin
                    beat_cnt_next_s = beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (beat_cnt_r == LAST_BEAT) begin
                        next_state_s = RELEASE;
                    end else begin
                        next_state_s = GRANT_I;
                    end
                end else begin
                    next_state_s = GRANT_I;
                end
            end
            GRANT_D: begin
                if (!d_req) begin
                    next_state_s = RELEASE;
                end else if (mem_ack) begin
                    beat_cnt_next_s = beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (beat_cnt_r == LAST_BEAT) begin
                        next_state_s = RELEASE;
                    end else begin
                        next_state_s = GRANT_D;
                    end
                end else begin
                    next_state_s = GRANT_D;
                end
            end
            RELEASE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Datapath steering: connect only the owning requester, everything else held at 0
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {XLEN{1'b0}};
        mem_wdata = {XLEN{1'b0}};
        i_ack     = 1'b0;
        i_data    = {XLEN{1'b0}};
        d_ack     = 1'b0;
        d_data    = {XLEN{1'b0}};
        grant     = 2'b00;
        case (state_r)
            GRANT_I: begin
                grant    = 2'b01;
                mem_req  = i_req;
                mem_addr = i_addr;
                // an ack arriving in the cycle the requester aborts is dropped
                i_ack    = mem_ack & i_req;
                i_data   = mem_data;
            end
            GRANT_D: begin
                grant     = 2'b10;
                mem_req   = d_req;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_ack     = mem_ack & d_req;
                d_data    = mem_data;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
        busy = (grant != 2'b00);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single instruction/data memory port between the I-cache refill controller and the D-cache refill/writeback controller. The arbiter grants one requester for a whole burst of `BEATS` word transfers. It routes address, write data and acknowledge between the granted requester and memory, and alternates priority round-robin when both requesters contend. It sits between the two cache controllers and the memory model/bus.

## Interface
- `BEATS`, 4: word transfers (acks) per granted burst.
- `XLEN` comes from the ISA include (32).

- `clk` in 1: clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: I-side request; held high for the whole burst.
- `i_addr` in XLEN: I-side word address; the requester advances it after each ack.
- `i_data` out XLEN: read data to the I side.
- `i_ack` out 1: per-beat acknowledge to the I side.
- `d_req` in 1: D-side request.
- `d_we` in 1: D-side write (writeback) burst when 1, refill when 0.
- `d_addr` in XLEN: D-side word address.
- `d_wdata` in XLEN: D-side write data.
- `d_data` out XLEN: read data to the D side.
- `d_ack` out 1: per-beat acknowledge to the D side.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write enable.
- `mem_addr` out XLEN: memory address.
- `mem_wdata` out XLEN: memory write data.
- `mem_data` in XLEN: memory read data.
- `mem_ack` in 1: memory beat acknowledge.
- `grant` out 2: 2'b01 when the I side owns the port, 2'b10 when the D side owns it, 2'b00 when no one does.
- `busy` out 1: high when `grant` is nonzero.

## Operation
- **States**
  - IDLE: no grant.
  - GRANT_I: I side owns the port.
  - GRANT_D: D side owns the port.
  - RELEASE: single holdoff cycle, no grant.
- **Registers**
  - `state`.
  - `beat_cnt`, width clog2(`BEATS`)+1.
  - `last_grant`, 1 bit: 0 = I, 1 = D.
- **Transitions from IDLE**
  - Only `i_req`: go to GRANT_I.
  - Only `d_req`: go to GRANT_D.
  - Both: grant the side not equal to `last_grant`.
  - On any grant: clear `beat_cnt` and load `last_grant` with the granted side.
- **Transitions from GRANT_x**
  - Each `mem_ack` increments `beat_cnt`.
  - On the ack where `beat_cnt == BEATS-1`, go to RELEASE.
  - If the granted `x_req` is low in any GRANT cycle (requester aborted), go to RELEASE at once. Any `mem_ack` in that same cycle is dropped, not forwarded.
- **Transitions from RELEASE**
  - Always go to IDLE after one cycle, ignoring all requests.
  - Purpose: requesters deassert `req` one cycle after their final ack. RELEASE prevents re-granting on that stale `req`.
- **Datapath** (combinational from `state`)
  - GRANT_I:
    - `mem_req = i_req`, `mem_addr = i_addr`, `mem_we = 0`.
    - `i_ack = mem_ack`, `i_data = mem_data`.
  - GRANT_D:
    - `mem_req = d_req`, `mem_addr = d_addr`, `mem_we = d_we`, `mem_wdata = d_wdata`.
    - `d_ack = mem_ack`, `d_data = mem_data`.
  - All other cases:
    - `mem_req`, `mem_we`, `i_ack` and `d_ack` are 0.
    - `mem_addr`, `mem_wdata`, `i_data` and `d_data` are 0.
- **Stray acks:** a `mem_ack` in IDLE or RELEASE is ignored. It is never forwarded and does not change `beat_cnt`.
- **Ack gating:** the non-granted side's `ack` and `data` stay 0 throughout.

## Timing
- **Reset** (`reset_n` low, asynchronous)
  - `state` = IDLE, `beat_cnt` = 0, `last_grant` = 1, so the I side wins the first tie.
  - All outputs are 0 while in reset.
- **Grant latency:** `req` seen in IDLE at edge N gives `grant` and `mem_req` high after edge N (one cycle).
- **Burst end**
  - The final ack is forwarded in the same cycle it arrives.
  - `grant` drops after that edge.
  - RELEASE lasts one cycle.
  - The earliest next grant is 2 cycles after the final ack edge.
- **Burst length:** exactly `BEATS` acks forwarded per grant, unless aborted.
- **Reset mid-burst:** the arbiter returns to IDLE immediately. Any in-flight memory transaction is abandoned.
- **Simultaneous events:** a request arriving during GRANT or RELEASE waits. Requests are sampled only in IDLE.

## Test plan
- **I-only refill:** `i_req`=1, `i_addr`=0x100, memory acks every cycle with 0xA0..0xA3 -> `grant`=01 one cycle later; `i_ack` ×4 with `i_data` 0xA0..0xA3; then `grant`=00 for 2 cycles (RELEASE, IDLE) even though `i_req` is still high the cycle after the 4th ack.
- **Tie after reset:** `i_req`=`d_req`=1 in the same cycle -> I granted first. After its 4 beats and RELEASE, D is granted. With both still requesting afterwards, I is granted next (strict alternation).
- **D writeback:** `d_req`=1, `d_we`=1, `d_wdata`=0xDEADBEEF, acks with 2-cycle gaps -> `mem_we`=1 and `mem_wdata` is passed through; exactly 4 `d_ack`; `i_ack` stays 0 throughout.
- **Abort:** `i_req` dropped after 2 acks while a `mem_ack` is high -> that ack is not forwarded; RELEASE, then IDLE; `beat_cnt` is cleared on the next grant.
- **Stray ack:** `mem_ack`=1 in IDLE with no requests -> `i_ack`=`d_ack`=0, and the state stays IDLE.
- **Async reset mid-burst:** `reset_n` low during GRANT_D beat 2 -> `mem_req`, `grant` and `busy` go 0 without a clock edge; after release the first tie goes to I.
